// File: rtl/bus_data_responder.sv
// bus_data_responder: data-bus responder backed by a byte-strobed word RAM.
// Define BUS_DATA_RESP_RANGE_CHECK_EN to fail out-of-range accesses and flag range_err.
`ifndef BUS_WIDTH
`define BUS_WIDTH 32
`endif
`ifndef BUS_RESP_WIDTH
`define BUS_RESP_WIDTH 2
`endif
`ifndef DATA_WRITE_RESP_OK
`define DATA_WRITE_RESP_OK 2'b00
`endif
`ifndef DATA_WRITE_RESP_FAIL
`define DATA_WRITE_RESP_FAIL 2'b10
`endif

module bus_data_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       dr_addr_valid,
    input  logic [`BUS_WIDTH-1:0]      dr_addr,
    output logic                       dr_addr_ready,
    output logic                       dr_data_valid,
    output logic [`BUS_WIDTH-1:0]      dr_data,
    input  logic                       dr_data_ready,
    input  logic                       dw_data_addr_valid,
    input  logic [`BUS_WIDTH-1:0]      dw_addr,
    input  logic [`BUS_WIDTH-1:0]      dw_data,
    input  logic [`BUS_WIDTH/8-1:0]    dw_strobe,
    output logic                       dw_data_addr_ready,
    output logic                       dw_resp_valid,
    output logic [`BUS_RESP_WIDTH-1:0] dw_resp,
`ifdef BUS_DATA_RESP_RANGE_CHECK_EN
    output logic                       range_err,
`endif
    input  logic                       dw_resp_ready
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int NB = `BUS_WIDTH / 8;
    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_t;

    logic [`BUS_WIDTH-1:0] r_mem [DEPTH_WORDS];

    r_state_t                   r_r_state;
    logic                       r_r_ready;
    logic                       r_r_valid;
    logic [`BUS_WIDTH-1:0]      r_r_data;
    logic [3:0]                 r_r_cnt;
    w_state_t                   r_w_state;
    logic                       r_w_ready;
    logic                       r_w_valid;
    logic [`BUS_RESP_WIDTH-1:0] r_w_resp;
    logic [3:0]                 r_w_cnt;

    logic [AW-1:0]         w_ridx;
    logic [AW-1:0]         w_widx;
    logic                  w_r_oor;
    logic                  w_w_oor;
    logic                  w_w_fire;
    logic                  w_mem_we;
    logic [`BUS_WIDTH-1:0] w_r_word;
    logic                  w_unused;

    assign w_ridx   = dr_addr[AW+1:2];
    assign w_widx   = dw_addr[AW+1:2];
    assign w_unused = ^{dr_addr[1:0], dw_addr[1:0],
                        dr_addr[`BUS_WIDTH-1:AW+2], dw_addr[`BUS_WIDTH-1:AW+2]};

`ifdef BUS_DATA_RESP_RANGE_CHECK_EN
    logic r_range_err;

    assign w_r_oor   = |dr_addr[`BUS_WIDTH-1:AW+2];
    assign w_w_oor   = |dw_addr[`BUS_WIDTH-1:AW+2];
    assign range_err = r_range_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_range_err <= 1'b0;
        end else if ((dr_addr_valid && r_r_ready && w_r_oor) ||
                     (w_w_fire && w_w_oor)) begin
            r_range_err <= 1'b1;
        end
    end
`else
    assign w_r_oor = 1'b0;
    assign w_w_oor = 1'b0;
`endif

    assign w_w_fire = dw_data_addr_valid && r_w_ready;
    assign w_mem_we = w_w_fire && !w_w_oor && !rst;
    assign w_r_word = w_r_oor ? '0 : r_mem[w_ridx];

    // Same-edge read of a word being written sees the old contents (NBA ordering).
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int i = 0; i < NB; i++) begin
                if (dw_strobe[i]) r_mem[w_widx][8*i +: 8] <= dw_data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_r_state <= R_IDLE;
            r_r_ready <= 1'b1;
            r_r_valid <= 1'b0;
            r_r_data  <= '0;
            r_r_cnt   <= '0;
        end else begin
            unique case (r_r_state)
                R_IDLE: if (dr_addr_valid) begin
                    r_r_data  <= w_r_word;
                    r_r_ready <= 1'b0;
                    if (LATENCY == 1) begin
                        r_r_state <= R_RESP;
                        r_r_valid <= 1'b1;
                    end else begin
                        r_r_state <= R_WAIT;
                        r_r_cnt   <= LAT_M1;
                    end
                end
                R_WAIT: begin
                    r_r_cnt <= r_r_cnt - 4'd1;
                    if (r_r_cnt == 4'd1) begin
                        r_r_state <= R_RESP;
                        r_r_valid <= 1'b1;
                    end
                end
                R_RESP: if (dr_data_ready) begin
                    r_r_state <= R_IDLE;
                    r_r_valid <= 1'b0;
                    r_r_ready <= 1'b1;
                end
                default: r_r_state <= R_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_w_state <= W_IDLE;
            r_w_ready <= 1'b1;
            r_w_valid <= 1'b0;
            r_w_resp  <= `DATA_WRITE_RESP_OK;
            r_w_cnt   <= '0;
        end else begin
            unique case (r_w_state)
                W_IDLE: if (dw_data_addr_valid) begin
                    r_w_resp  <= w_w_oor ? `DATA_WRITE_RESP_FAIL : `DATA_WRITE_RESP_OK;
                    r_w_ready <= 1'b0;
                    if (LATENCY == 1) begin
                        r_w_state <= W_RESP;
                        r_w_valid <= 1'b1;
                    end else begin
                        r_w_state <= W_WAIT;
                        r_w_cnt   <= LAT_M1;
                    end
                end
                W_WAIT: begin
                    r_w_cnt <= r_w_cnt - 4'd1;
                    if (r_w_cnt == 4'd1) begin
                        r_w_state <= W_RESP;
                        r_w_valid <= 1'b1;
                    end
                end
                W_RESP: if (dw_resp_ready) begin
                    r_w_state <= W_IDLE;
                    r_w_valid <= 1'b0;
                    r_w_ready <= 1'b1;
                end
                default: r_w_state <= W_IDLE;
            endcase
        end
    end

    assign dr_addr_ready      = r_r_ready;
    assign dr_data_valid      = r_r_valid;
    assign dr_data            = r_r_data;
    assign dw_data_addr_ready = r_w_ready;
    assign dw_resp_valid      = r_w_valid;
    assign dw_resp            = r_w_resp;

endmodule

// File: tb/tb_bus_data_responder.sv
// tb_bus_data_responder: directed and randomized checks of bus_data_responder
// against a word-array memory model, run at LATENCY=4 with back-pressure.
`ifndef BUS_WIDTH
`define BUS_WIDTH 32
`endif
`ifndef BUS_RESP_WIDTH
`define BUS_RESP_WIDTH 2
`endif
`ifndef DATA_WRITE_RESP_OK
`define DATA_WRITE_RESP_OK 2'b00
`endif
`ifndef DATA_WRITE_RESP_FAIL
`define DATA_WRITE_RESP_FAIL 2'b10
`endif

module tb_bus_data_responder;

    localparam int DEPTH = 1024;
    localparam int LAT   = 4;
`ifdef BUS_DATA_RESP_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        dr_addr_valid = 1'b0;
    logic [31:0] dr_addr = '0;
    logic        dr_addr_ready;
    logic        dr_data_valid;
    logic [31:0] dr_data;
    logic        dr_data_ready = 1'b0;
    logic        dw_data_addr_valid = 1'b0;
    logic [31:0] dw_addr = '0;
    logic [31:0] dw_data = '0;
    logic [3:0]  dw_strobe = '0;
    logic        dw_data_addr_ready;
    logic        dw_resp_valid;
    logic [1:0]  dw_resp;
    logic        dw_resp_ready = 1'b0;
`ifdef BUS_DATA_RESP_RANGE_CHECK_EN
    logic        range_err;
`endif

    always #5 clk = ~clk;

    bus_data_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk(clk),
        .rst(rst),
        .dr_addr_valid(dr_addr_valid),
        .dr_addr(dr_addr),
        .dr_addr_ready(dr_addr_ready),
        .dr_data_valid(dr_data_valid),
        .dr_data(dr_data),
        .dr_data_ready(dr_data_ready),
        .dw_data_addr_valid(dw_data_addr_valid),
        .dw_addr(dw_addr),
        .dw_data(dw_data),
        .dw_strobe(dw_strobe),
        .dw_data_addr_ready(dw_data_addr_ready),
        .dw_resp_valid(dw_resp_valid),
        .dw_resp(dw_resp),
`ifdef BUS_DATA_RESP_RANGE_CHECK_EN
        .range_err(range_err),
`endif
        .dw_resp_ready(dw_resp_ready)
    );

    logic [31:0] model [DEPTH];
    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit oor(input logic [31:0] a);
        return RC && ((a / (DEPTH * 4)) != 0);
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a / 4) % DEPTH);
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        return oor(a) ? 32'h0 : model[widx(a)];
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        if (!oor(a)) begin
            for (int i = 0; i < 4; i++) begin
                if (s[i]) model[widx(a)][8*i +: 8] = d[8*i +: 8];
            end
        end
    endtask

    function automatic logic [1:0] exp_resp(input logic [31:0] a);
        return oor(a) ? `DATA_WRITE_RESP_FAIL : `DATA_WRITE_RESP_OK;
    endfunction

    task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, input int hold);
        int n;
        logic [1:0] er;
        @(negedge clk);
        chk("w_ready_idle", 32'(dw_data_addr_ready), 32'd1);
        dw_data_addr_valid = 1'b1;
        dw_addr = a;
        dw_data = d;
        dw_strobe = s;
        @(negedge clk);
        dw_data_addr_valid = 1'b0;
        er = exp_resp(a);
        model_write(a, d, s);
        n = 1;
        while (!dw_resp_valid && n < 64) begin
            @(negedge clk);
            n++;
        end
        chk("w_latency", 32'(n), 32'(LAT));
        chk("w_busy", 32'(dw_data_addr_ready), 32'd0);
        chk("w_resp", 32'(dw_resp), 32'(er));
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            chk("w_hold", 32'({dw_resp_valid, dw_data_addr_ready, dw_resp}), 32'({2'b10, er}));
        end
        dw_resp_ready = 1'b1;
        @(negedge clk);
        dw_resp_ready = 1'b0;
        chk("w_done", 32'({dw_resp_valid, dw_data_addr_ready}), 32'b01);
    endtask

    task automatic do_read(input logic [31:0] a, input int hold, output logic [31:0] got);
        int n;
        logic [31:0] ed;
        @(negedge clk);
        chk("r_ready_idle", 32'(dr_addr_ready), 32'd1);
        dr_addr_valid = 1'b1;
        dr_addr = a;
        @(negedge clk);
        dr_addr_valid = 1'b0;
        ed = model_read(a);
        n = 1;
        while (!dr_data_valid && n < 64) begin
            @(negedge clk);
            n++;
        end
        chk("r_latency", 32'(n), 32'(LAT));
        chk("r_busy", 32'(dr_addr_ready), 32'd0);
        chk("r_data", dr_data, ed);
        got = dr_data;
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            chk("r_hold_ctl", 32'({dr_data_valid, dr_addr_ready}), 32'b10);
            chk("r_hold_data", dr_data, ed);
        end
        dr_data_ready = 1'b1;
        @(negedge clk);
        dr_data_ready = 1'b0;
        chk("r_done", 32'({dr_data_valid, dr_addr_ready}), 32'b01);
    endtask

    // Read and write accepted on the same edge; both channels run concurrently.
    task automatic do_both(input logic [31:0] ra, input logic [31:0] wa,
                           input logic [31:0] d, input logic [3:0] s, output logic [31:0] got);
        int n;
        logic [31:0] ed;
        logic [1:0] er;
        @(negedge clk);
        chk("b_ready_idle", 32'({dr_addr_ready, dw_data_addr_ready}), 32'b11);
        dr_addr_valid = 1'b1;
        dr_addr = ra;
        dw_data_addr_valid = 1'b1;
        dw_addr = wa;
        dw_data = d;
        dw_strobe = s;
        @(negedge clk);
        dr_addr_valid = 1'b0;
        dw_data_addr_valid = 1'b0;
        ed = model_read(ra);
        er = exp_resp(wa);
        model_write(wa, d, s);
        n = 1;
        while (!(dr_data_valid && dw_resp_valid) && n < 64) begin
            @(negedge clk);
            n++;
        end
        chk("b_latency", 32'(n), 32'(LAT));
        chk("b_rdata", dr_data, ed);
        chk("b_resp", 32'(dw_resp), 32'(er));
        got = dr_data;
        dr_data_ready = 1'b1;
        dw_resp_ready = 1'b1;
        @(negedge clk);
        dr_data_ready = 1'b0;
        dw_resp_ready = 1'b0;
        chk("b_done", 32'({dr_data_valid, dw_resp_valid, dr_addr_ready, dw_data_addr_ready}),
            32'b0011);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] got;
        logic [31:0] a;
        logic [31:0] d;
        int op;

        rst = 1'b1;
        #1;
        chk("rst_ctl", 32'({dr_addr_ready, dw_data_addr_ready, dr_data_valid, dw_resp_valid}),
            32'b1100);
        chk("rst_rdata", dr_data, 32'h0);
        chk("rst_resp", 32'(dw_resp), 32'(`DATA_WRITE_RESP_OK));
`ifdef BUS_DATA_RESP_RANGE_CHECK_EN
        chk("rst_range_err", 32'(range_err), 32'd0);
`endif
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int w = 0; w < DEPTH; w++) do_write(32'(w * 4), 32'h0, 4'hF, 0);

        do_write(32'h10, 32'hA5A5_1234, 4'hF, 0);
        do_read(32'h10, 0, got);
        chk("plan_basic", got, 32'hA5A5_1234);

        do_write(32'h20, 32'hFFFF_FFFF, 4'hF, 1);
        do_write(32'h20, 32'h0000_AB00, 4'b0010, 0);
        do_read(32'h23, 0, got);
        chk("plan_strobe", got, 32'hFFFF_ABFF);
        do_write(32'h20, 32'h1234_5678, 4'b0000, 2);
        do_read(32'h20, 0, got);
        chk("plan_strobe0", got, 32'hFFFF_ABFF);

        do_read(32'h10, 3, got);

        do_write(32'h40, 32'h0, 4'hF, 0);
        do_both(32'h40, 32'h40, 32'h1, 4'hF, got);
        chk("plan_raw_old", got, 32'h0);
        do_read(32'h40, 0, got);
        chk("plan_raw_new", got, 32'h1);

        // Write parked in W_RESP, read in R_WAIT, then reset mid-cycle.
        @(negedge clk);
        dw_data_addr_valid = 1'b1;
        dw_addr = 32'h80;
        dw_data = 32'hCAFE_F00D;
        dw_strobe = 4'hF;
        @(negedge clk);
        dw_data_addr_valid = 1'b0;
        model_write(32'h80, 32'hCAFE_F00D, 4'hF);
        repeat (LAT) @(negedge clk);
        chk("rst_pre_wvalid", 32'(dw_resp_valid), 32'd1);
        dr_addr_valid = 1'b1;
        dr_addr = 32'h10;
        @(negedge clk);
        dr_addr_valid = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_async", 32'({dr_data_valid, dw_resp_valid, dr_addr_ready, dw_data_addr_ready}),
            32'b0011);
        @(negedge clk);
        rst = 1'b0;
        do_read(32'h80, 0, got);
        chk("rst_committed", got, 32'hCAFE_F00D);

        do_write(32'h0, 32'h0, 4'hF, 0);
        do_write(32'h1000, 32'h55, 4'hF, 0);
        do_read(32'h0, 0, got);
        chk("plan_wrap", got, RC ? 32'h0 : 32'h55);
`ifdef BUS_DATA_RESP_RANGE_CHECK_EN
        chk("range_err_set", 32'(range_err), 32'd1);
`endif

        for (int it = 0; it < 60; it++) begin
            op = int'($urandom_range(0, 2));
            a = 32'($urandom_range(0, 63) * 4 + $urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) a = a | ($urandom & 32'hFFFF_F000);
            d = $urandom;
            if (op == 0) begin
                do_write(a, d, 4'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
            end else if (op == 1) begin
                do_read(a, int'($urandom_range(0, 3)), got);
            end else begin
                do_both(32'($urandom_range(0, 63) * 4), a, d, 4'($urandom_range(0, 15)), got);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
